// File: rtl/sprite_fetcher.sv
// ---------------------------------------------------------------------------
// sprite_fetcher
//   Walks the per-scanline active sprite list one entry at a time. For every
//   tile of an entry it reads one tilemap word from VRAM and hands a tile job
//   (line-buffer address, bitmap address, horizontal flip) to the renderer.
//
// Ports
//   clk_draw, rst_draw    draw-domain clock, synchronous active-high reset
//   line                  one-cycle pulse at the start of every scanline
//   sprite_index [8:0]    active-list read index toward the matcher
//   valid                 matcher entry-valid (registered, one cycle late)
//   tilemap_addr [25:0]   {x_flip, tile_count[6:0], tilemap_addr[17:0]}
//   bitmap_addr  [28:0]   {lb_addr[10:0], tile_bitmap_addr[17:0]}
//   mem_req/mem_addr      VRAM tilemap-word read, held until mem_ack
//   mem_ack/mem_data      read acknowledge, data valid with ack
//   tile_valid/tile_ready tile-job handshake
//   tile_lb_addr, tile_bmp_addr, tile_x_flip   tile-job payload
//   busy                  list walk in progress
//   overrun               one-cycle pulse: line arrived while still walking
// ---------------------------------------------------------------------------
module sprite_fetcher (
    input  logic        clk_draw,
    input  logic        rst_draw,
    input  logic        line,
    output logic [8:0]  sprite_index,
    input  logic        valid,
    input  logic [25:0] tilemap_addr,
    input  logic [28:0] bitmap_addr,
    output logic        mem_req,
    output logic [17:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic        tile_valid,
    input  logic        tile_ready,
    output logic [10:0] tile_lb_addr,
    output logic [17:0] tile_bmp_addr,
    output logic        tile_x_flip,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CHECK, S_FETCH, S_EMIT, S_DONE
    } state_t;

    state_t state, state_next;

    // matcher entry fields
    logic        in_x_flip;
    logic [6:0]  in_count;
    logic [17:0] in_tmap;
    logic [10:0] in_lb;
    logic [17:0] in_bmp;

    assign in_x_flip = tilemap_addr[25];
    assign in_count  = tilemap_addr[24:18];
    assign in_tmap   = tilemap_addr[17:0];
    assign in_lb     = bitmap_addr[28:18];
    assign in_bmp    = bitmap_addr[17:0];

    // entry latched at CHECK; k is the tile being fetched/emitted
    logic        ent_x_flip;
    logic [6:0]  ent_count;
    logic [17:0] ent_tmap;
    logic [10:0] ent_lb;
    logic [17:0] ent_bmp;
    logic [6:0]  k;

    logic        last_index;
    logic        more_tiles;
    logic [6:0]  next_k;
    logic [6:0]  tile_slot;
    logic [10:0] lb_offset;

    logic        entry_take;
    logic        entry_skip;
    logic        fetch_done;
    logic        tile_done;
    logic        advance;

    assign last_index = &sprite_index;
    assign next_k     = k + 7'd1;
    assign more_tiles = ({1'b0, k} + 8'd1) < {1'b0, ent_count};
    // flipped sprites place tile k mirrored from the right edge
    assign tile_slot  = ent_x_flip ? (ent_count - 7'd1 - k) : k;
    assign lb_offset  = {tile_slot, 4'b0000};
    assign advance    = entry_skip || (tile_done && !more_tiles);
    assign busy       = (state != S_IDLE) && (state != S_DONE);

    always_ff @(posedge clk_draw) begin
        if (rst_draw) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        entry_take = 1'b0;
        entry_skip = 1'b0;
        fetch_done = 1'b0;
        tile_done  = 1'b0;
        case (state)
            S_SETUP: state_next = S_CHECK;
            S_CHECK: begin
                if (!valid) begin
                    state_next = S_DONE;
                end else if (in_count == 7'd0) begin
                    entry_skip = 1'b1;
                    state_next = last_index ? S_DONE : S_SETUP;
                end else begin
                    entry_take = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    fetch_done = 1'b1;
                    state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                if (tile_ready) begin
                    tile_done  = 1'b1;
                    if (more_tiles)      state_next = S_FETCH;
                    else if (last_index) state_next = S_DONE;
                    else                 state_next = S_SETUP;
                end
            end
            default: ;
        endcase
        // a new scanline restarts the walk from any state
        if (line) state_next = S_SETUP;
    end

    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            sprite_index  <= 9'd0;
            mem_req       <= 1'b0;
            mem_addr      <= 18'd0;
            tile_valid    <= 1'b0;
            tile_lb_addr  <= 11'd0;
            tile_bmp_addr <= 18'd0;
            tile_x_flip   <= 1'b0;
            overrun       <= 1'b0;
            k             <= 7'd0;
            ent_x_flip    <= 1'b0;
            ent_count     <= 7'd0;
            ent_tmap      <= 18'd0;
            ent_lb        <= 11'd0;
            ent_bmp       <= 18'd0;
        end else begin
            overrun <= 1'b0;
            if (line) begin
                // an ack or accept in this same cycle is dropped
                sprite_index <= 9'd0;
                k            <= 7'd0;
                mem_req      <= 1'b0;
                tile_valid   <= 1'b0;
                overrun      <= busy;
            end else begin
                if (entry_take) begin
                    ent_x_flip <= in_x_flip;
                    ent_count  <= in_count;
                    ent_tmap   <= in_tmap;
                    ent_lb     <= in_lb;
                    ent_bmp    <= in_bmp;
                    k          <= 7'd0;
                    mem_req    <= 1'b1;
                    mem_addr   <= in_tmap;
                end
                if (advance && !last_index) sprite_index <= sprite_index + 9'd1;
                if (fetch_done) begin
                    mem_req       <= 1'b0;
                    tile_valid    <= 1'b1;
                    tile_lb_addr  <= ent_lb + lb_offset;
                    tile_bmp_addr <= ent_bmp + {9'd0, mem_data[8:0]};
                    tile_x_flip   <= ent_x_flip ^ mem_data[15];
                end
                if (tile_done) begin
                    tile_valid <= 1'b0;
                    if (more_tiles) begin
                        k        <= next_k;
                        mem_req  <= 1'b1;
                        mem_addr <= ent_tmap + {11'd0, next_k};
                    end
                end
            end
        end
    end

endmodule
